// File: rtl/add_pkg.sv
// Shared definitions for the byte-serial adder: sequencer states and byte width.
package add_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_8_bit.sv
// Combinational 8-bit adder with carry in and carry out.
module add_8_bit
  import add_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              carryIn,
  output logic [BYTE_W-1:0] sum,
  output logic              carryOut
);

  logic [BYTE_W:0] full;

  always_comb begin
    full     = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, carryIn};
    sum      = full[BYTE_W-1:0];
    carryOut = full[BYTE_W];
  end

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial wide add/subtract: feeds add_8_bit one byte pair per cycle, LSB first,
// carrying between bytes through a register, and presents the result with valid/ready.
module multibyte_add_seq
  import add_pkg::*;
#(
  parameter int NUM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_a,
  input  logic [8*NUM_BYTES-1:0] in_b,
  input  logic                   in_carry,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_sum,
  output logic                   out_carry,
  output logic                   out_ovf
);

  localparam int W     = BYTE_W * NUM_BYTES;
  localparam int IDX_W = $clog2(NUM_BYTES);

  state_t             state, nextState;
  logic [W-1:0]       opA, opB;
  logic [W-1:0]       acc, accNext;
  logic [W-1:0]       outSum;
  logic               outCarry, outOvf;
  logic               carryReg;
  logic [IDX_W-1:0]   idx;
  logic               lastByte;
  logic [BYTE_W-1:0]  byteSum;
  logic               byteCarry;
  logic               byteOvf;

  add_8_bit u_add (
    .a        (opA[BYTE_W-1:0]),
    .b        (opB[BYTE_W-1:0]),
    .carryIn  (carryReg),
    .sum      (byteSum),
    .carryOut (byteCarry)
  );

  // Carry into bit 7 is recovered from the adder's own bits, so the adder needs no extra port.
  assign byteOvf = opA[BYTE_W-1] ^ opB[BYTE_W-1] ^ byteSum[BYTE_W-1] ^ byteCarry;

  always_comb begin
    nextState = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    lastByte  = (idx == IDX_W'(NUM_BYTES - 1));
    accNext   = acc;
    accNext[int'(idx)*BYTE_W +: BYTE_W] = byteSum;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nextState = RUN;
      end
      RUN: begin
        if (lastByte) nextState = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      opA      <= '0;
      opB      <= '0;
      acc      <= '0;
      outSum   <= '0;
      outCarry <= 1'b0;
      outOvf   <= 1'b0;
      carryReg <= 1'b0;
      idx      <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (in_valid) begin
            opA      <= in_a;
            opB      <= in_sub ? ~in_b : in_b;
            carryReg <= in_sub ? 1'b1 : in_carry;
            idx      <= '0;
          end
        end
        RUN: begin
          acc      <= accNext;
          carryReg <= byteCarry;
          opA      <= opA >> BYTE_W;
          opB      <= opB >> BYTE_W;
          idx      <= idx + IDX_W'(1);
          // Output registers change only when a new result completes, so they hold otherwise.
          if (lastByte) begin
            outSum   <= accNext;
            outCarry <= byteCarry;
            outOvf   <= byteOvf;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum   = outSum;
  assign out_carry = outCarry;
  assign out_ovf   = outOvf;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Bench for multibyte_add_seq with NUM_BYTES=4: directed cases plus random add/sub against an arithmetic model.
module tb_multibyte_add_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_carry, in_sub;
  logic         out_valid, out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry, out_ovf;

  int tests = 0;
  int fails = 0;

  multibyte_add_seq #(.NUM_BYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_carry  (in_carry),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  // Plain W-bit arithmetic: carry is the bit beyond W for add, "no borrow" for subtract.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                input logic sub, output logic [W-1:0] s, output logic c,
                                output logic o);
    logic [W:0] r;
    if (sub) begin
      r = {1'b0, a} - {1'b0, b};
      s = r[W-1:0];
      c = (a >= b);
      o = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      s = r[W-1:0];
      c = r[W];
      o = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end
  endfunction

  // Drives one request, scrambles inputs during the run, collects the result and acknowledges it.
  task automatic transact(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, output logic [W-1:0] s, output logic c,
                          output logic o, output int lat);
    @(posedge clk); #1;
    in_a = a; in_b = b; in_carry = cin; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    in_a = $urandom; in_b = $urandom; in_carry = 1'($urandom); in_sub = 1'($urandom);
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    s = out_sum; c = out_carry; o = out_ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    tests++;
    if (out_sum !== '0 || out_carry !== 1'b0 || out_ovf !== 1'b0) begin
      fails++; $display("FAIL reset_out: sum=%h c=%b o=%b expected 0/0/0", out_sum, out_carry, out_ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  // Runs one operation and compares everything against the model and the NB-cycle latency.
  task automatic test_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub);
    logic [W-1:0] s, es;
    logic c, o, ec, eo;
    int lat;
    transact(a, b, cin, sub, s, c, o, lat);
    model(a, b, cin, sub, es, ec, eo);
    tests++;
    if (s !== es || c !== ec || o !== eo) begin
      fails++;
      $display("FAIL %s: got sum=%h c=%b o=%b expected sum=%h c=%b o=%b", name, s, c, o, es, ec, eo);
    end
    tests++;
    if (lat !== NB) begin
      fails++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, NB);
    end
  endtask

  task automatic test_carry_boundary();
    test_directed("carry_boundary", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    tests++;
    if (out_sum !== 32'h0000_0100) begin
      fails++; $display("FAIL carry_boundary_const: got %h expected 00000100", out_sum);
    end
  endtask

  task automatic test_wrap();
    test_directed("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    tests++;
    if (out_sum !== 32'h0 || out_carry !== 1'b1) begin
      fails++; $display("FAIL wrap_const: got sum=%h c=%b expected 00000000/1", out_sum, out_carry);
    end
    test_directed("carry_in", 32'h0, 32'h0, 1'b1, 1'b0);
    tests++;
    if (out_sum !== 32'h1) begin
      fails++; $display("FAIL carry_in_const: got %h expected 00000001", out_sum);
    end
  endtask

  task automatic test_subtract();
    test_directed("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1);
    tests++;
    if (out_sum !== 32'hFFFF_FFFE || out_carry !== 1'b0 || out_ovf !== 1'b0) begin
      fails++; $display("FAIL sub_borrow_const: got sum=%h c=%b o=%b expected FFFFFFFE/0/0",
                        out_sum, out_carry, out_ovf);
    end
    test_directed("sub_noborrow", 32'd7, 32'd5, 1'b1, 1'b1);
    tests++;
    if (out_sum !== 32'h2 || out_carry !== 1'b1) begin
      fails++; $display("FAIL sub_noborrow_const: got sum=%h c=%b expected 00000002/1", out_sum, out_carry);
    end
  endtask

  task automatic test_overflow();
    test_directed("ovf_add", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    tests++;
    if (out_sum !== 32'h8000_0000 || out_ovf !== 1'b1 || out_carry !== 1'b0) begin
      fails++; $display("FAIL ovf_add_const: got sum=%h o=%b c=%b expected 80000000/1/0",
                        out_sum, out_ovf, out_carry);
    end
    test_directed("ovf_sub", 32'h8000_0000, 32'h1, 1'b0, 1'b1);
    tests++;
    if (out_sum !== 32'h7FFF_FFFF || out_ovf !== 1'b1) begin
      fails++; $display("FAIL ovf_sub_const: got sum=%h o=%b expected 7FFFFFFF/1", out_sum, out_ovf);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 8 == 0) a = 32'hFFFF_FFFF;
      if (i % 8 == 1) b = 32'h8000_0000;
      if (i % 8 == 2) a = 32'h7FFF_FFFF;
      test_directed($sformatf("random%0d", i), a, b, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] es;
    logic ec, eo;
    int waitCnt;
    model(32'h0102_03F0, 32'h00FF_0020, 1'b1, 1'b0, es, ec, eo);
    @(posedge clk); #1;
    in_a = 32'h0102_03F0; in_b = 32'h00FF_0020; in_carry = 1'b1; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    waitCnt = 0;
    while (!out_valid && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    tests++;
    if (out_valid !== 1'b1 || out_sum !== es || out_carry !== ec || out_ovf !== eo) begin
      fails++; $display("FAIL bp_result: valid=%b sum=%h c=%b o=%b expected 1/%h/%b/%b",
                        out_valid, out_sum, out_carry, out_ovf, es, ec, eo);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      in_a = $urandom;
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== es || out_carry !== ec || out_ovf !== eo) begin
        fails++; $display("FAIL bp_hold%0d: valid=%b ready=%b sum=%h expected 1/0/%h",
                          i, out_valid, in_ready, out_sum, es);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== es) begin
      fails++; $display("FAIL bp_release: valid=%b ready=%b sum=%h expected 0/1/%h",
                        out_valid, in_ready, out_sum, es);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== es) begin
      fails++; $display("FAIL bp_idle_hold: valid=%b ready=%b sum=%h expected 0/1/%h",
                        out_valid, in_ready, out_sum, es);
    end
  endtask

  task automatic test_reset_midrun();
    logic [W-1:0] s;
    logic c, o;
    int lat;
    @(posedge clk); #1;
    in_a = 32'hDEAD_BEEF; in_b = 32'h1357_9BDF; in_carry = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 || out_carry !== 1'b0) begin
      fails++; $display("FAIL midrun_reset: valid=%b ready=%b sum=%h c=%b expected 0/1/0/0",
                        out_valid, in_ready, out_sum, out_carry);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_sum !== '0) begin
      fails++; $display("FAIL midrun_no_partial: valid=%b sum=%h expected 0/0", out_valid, out_sum);
    end
    transact(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, s, c, o, lat);
    tests++;
    if (s !== 32'h2345_6789 || c !== 1'b0 || lat !== NB) begin
      fails++; $display("FAIL midrun_after: got sum=%h c=%b lat=%0d expected 23456789/0/%0d", s, c, lat, NB);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_carry = 1'b0; in_sub = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_carry_boundary();
    test_wrap();
    test_subtract();
    test_overflow();
    test_random();
    test_backpressure();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
